// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
// The runtime divisor handshake is compiled in only when CLKDIV_CFG_EN is defined.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEF  = 18;
  localparam int unsigned DIV_MAX_W  = 32;
  localparam int unsigned NUM_CH_MAX = 8;

  // Reset divisors for the pixel enable and the 7-segment refresh.
  localparam int unsigned DIV_PIX = 2;
  localparam int unsigned DIV_SEG = 131072;

  typedef logic [DIV_MAX_W-1:0] div_t;

  // Length of the high phase of tick: odd divisors get the extra cycle high.
  function automatic div_t ceil_half(input div_t div);
    return (div >> 1) + div_t'(div[0]);
  endfunction

  // A divisor of 0 behaves as 1.
  function automatic div_t div_sat(input div_t div);
    return (div == '0) ? div_t'(1) : div;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, registered enable/tick outputs and, when
// CLKDIV_CFG_EN is defined, the active/pending divisor registers.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_PIX)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sync_i,
`ifdef CLKDIV_CFG_EN
  input  logic             xfer_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             pend_o,
`endif
  output logic             en_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] DIV_RST_SAT = CNT_W'(div_sat(DIV_MAX_W'(DIV_RST)));

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] div_nxt;
  logic             term_c;

`ifdef CLKDIV_CFG_EN
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;

  assign div_cur = div_act_q;
  assign div_nxt = div_act_d;
  assign pend_o  = pend_q;

  // Divisor update: restart applies at once, otherwise only at terminal count.
  always_comb begin
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    if (sync_i) begin
      if (xfer_i) begin
        div_act_d = div_i;
      end else if (pend_q) begin
        div_act_d = div_pend_q;
      end
      pend_d = 1'b0;
    end else begin
      if (term_c && pend_q) begin
        div_act_d = div_pend_q;
        pend_d    = 1'b0;
      end
      // A transfer landing on terminal count waits for the next one.
      if (xfer_i) begin
        div_pend_d = div_i;
        pend_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div_act_q  <= DIV_RST_SAT;
      div_pend_q <= DIV_RST_SAT;
      pend_q     <= 1'b0;
    end else begin
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
    end
  end
`else
  assign div_cur = DIV_RST_SAT;
  assign div_nxt = DIV_RST_SAT;
`endif

  assign term_c = (cnt_q == (div_cur - CNT_W'(1)));

  // Counter and output next state; tick follows the post-edge count and divisor.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    en_d   = 1'b0;
    if (sync_i) begin
      cnt_d = '0;
    end else if (term_c) begin
      cnt_d = '0;
      en_d  = 1'b1;
    end
    tick_d = (cnt_d < CNT_W'(ceil_half(DIV_MAX_W'(div_nxt))));
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      en_q   <= 1'b0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      tick_q <= tick_d;
    end
  end

  assign en_o   = en_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock-enable generator (top level).
// Define CLKDIV_CFG_EN to include the runtime divisor valid/ready handshake.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned              NUM_CH   = 2,
  parameter int unsigned              CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0]  DIV_INIT = {CNT_W'(DIV_SEG), CNT_W'(DIV_PIX)}
) (
  input  logic                                           clk,
  input  logic                                           clr,
  input  logic                                           sync_i,
  input  logic                                           cfg_valid,
  output logic                                           cfg_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                               cfg_div,
  output logic [NUM_CH-1:0]                              en_o,
  output logic [NUM_CH-1:0]                              tick_o
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CH_N = 1 << CH_W;

  if (NUM_CH == 0 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("clkdiv_multi: NUM_CH must be 1..8");
  end
  if (CNT_W == 0 || CNT_W > DIV_MAX_W) begin : g_bad_cnt_w
    $error("clkdiv_multi: CNT_W must be 1..32");
  end

  logic [NUM_CH-1:0] en_w;
  logic [NUM_CH-1:0] tick_w;

`ifdef CLKDIV_CFG_EN
  logic [NUM_CH-1:0] pend_w;
  logic [NUM_CH-1:0] xfer_c;
  logic [CH_N-1:0]   pend_ext;
  logic [CNT_W-1:0]  cfg_div_sat;
  logic              ch_ok_c;

  // Out-of-range channels always look ready so the request is silently dropped.
  assign ch_ok_c     = (32'(cfg_ch) < NUM_CH);
  assign pend_ext    = CH_N'(pend_w);
  assign cfg_ready   = ~ch_ok_c | ~pend_ext[cfg_ch];
  assign cfg_div_sat = CNT_W'(div_sat(DIV_MAX_W'(cfg_div)));
`else
  logic unused_cfg;

  assign cfg_ready  = 1'b0;
  assign unused_cfg = ^{cfg_valid, cfg_ch, cfg_div};
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef CLKDIV_CFG_EN
    assign xfer_c[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
`endif

    clkdiv_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk    (clk),
      .clr    (clr),
      .sync_i (sync_i),
`ifdef CLKDIV_CFG_EN
      .xfer_i (xfer_c[i]),
      .div_i  (cfg_div_sat),
      .pend_o (pend_w[i]),
`endif
      .en_o   (en_w[i]),
      .tick_o (tick_w[i])
    );
  end

  assign en_o   = en_w;
  assign tick_o = tick_w;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed self-checking bench for clkdiv_multi (ch1 reset divisor shortened to 9).
// Handshake steps are included when CLKDIV_CFG_EN is defined.
module tb_clkdiv_multi;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = 18;

  logic              clk = 1'b0;
  logic              clr;
  logic              sync_i;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [0:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] en_o;
  logic [NUM_CH-1:0] tick_o;

  int n_chk  = 0;
  int n_fail = 0;
  int e;
  int b0, d0, b1, d1;

  clkdiv_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_INIT ({18'd9, 18'd2})
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .sync_i    (sync_i),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .en_o      (en_o),
    .tick_o    (tick_o)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {en, tick} for a channel counting with divisor dd since its count was 0 at edge bb.
  function automatic logic [1:0] ex(input int ee, input int bb, input int dd);
    int c;
    c = (ee - bb) % dd;
    return {c == 0, c < (dd + 1) / 2};
  endfunction

  task automatic run(input int n, input string tag);
    logic [1:0] x0, x1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e++;
      x0 = ex(e, b0, d0);
      x1 = ex(e, b1, d1);
      chk($sformatf("%s e%0d en", tag, e), 32'(en_o), 32'({x1[1], x0[1]}));
      chk($sformatf("%s e%0d tick", tag, e), 32'(tick_o), 32'({x1[0], x0[0]}));
    end
  endtask

  initial begin
    clr = 1'b1; sync_i = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_div = '0;
    e = 0; b0 = 0; d0 = 2; b1 = 0; d1 = 9;
    repeat (3) @(negedge clk);
    chk("reset en", 32'(en_o), 0);
    chk("reset tick", 32'(tick_o), 3);
`ifdef CLKDIV_CFG_EN
    chk("reset ready", 32'(cfg_ready), 1);
`else
    chk("reset ready", 32'(cfg_ready), 0);
`endif
    clr = 1'b0;
    run(20, "init");

`ifdef CLKDIV_CFG_EN
    // ch0 -> 5 mid-period; old period of 2 completes at edge 22.
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 18'd5;
    #1 chk("ready ch0 idle", 32'(cfg_ready), 1);
    run(1, "xfer ch0");
    cfg_div = 18'd3;
    #1 chk("ready ch0 pending", 32'(cfg_ready), 0);
    run(1, "apply ch0");
    b0 = 22; d0 = 5;
    cfg_valid = 1'b0;
    #1 chk("ready ch0 applied", 32'(cfg_ready), 1);
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 18'd6;
    #1 chk("ready ch1 idle", 32'(cfg_ready), 1);
    run(1, "xfer ch1");
    cfg_valid = 1'b0;
    #1 chk("ready ch1 pending", 32'(cfg_ready), 0);
    cfg_ch = 1'b0;
    #1 chk("ready ch0 while ch1 pending", 32'(cfg_ready), 1);
    run(4, "ch1 old period");
    b1 = 27; d1 = 6;
    cfg_ch = 1'b1;
    #1 chk("ready ch1 applied", 32'(cfg_ready), 1);
    run(7, "ch1 div6");

    // Pending div=7 on ch1, then restart applies it immediately.
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 18'd7;
    run(1, "xfer ch1 div7");
    cfg_valid = 1'b0;
    #1 chk("ready ch1 pend7", 32'(cfg_ready), 0);
    sync_i = 1'b1;
    @(negedge clk); e++;
    chk("sync en", 32'(en_o), 0);
    chk("sync tick", 32'(tick_o), 3);
    sync_i = 1'b0;
    #1 chk("ready ch1 after sync", 32'(cfg_ready), 1);
    b0 = e; b1 = e; d1 = 7;
    run(14, "post sync");

    // Restart with a same-edge transfer of div 0 on ch0: behaves as 1.
    sync_i = 1'b1; cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = '0;
    @(negedge clk); e++;
    chk("sync2 en", 32'(en_o), 0);
    chk("sync2 tick", 32'(tick_o), 3);
    sync_i = 1'b0; cfg_valid = 1'b0;
    b0 = e; d0 = 1; b1 = e;
    run(6, "div0");

    // Transfer on ch1 terminal count stays pending; clr then discards it.
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 18'd3;
    run(1, "xfer ch1 at tc");
    cfg_valid = 1'b0;
    #1 chk("ready ch1 pend at tc", 32'(cfg_ready), 0);
`else
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 18'd5;
    #1 chk("ready tied low", 32'(cfg_ready), 0);
    run(10, "cfg ignored");
    cfg_valid = 1'b0; sync_i = 1'b1;
    @(negedge clk); e++;
    chk("sync en", 32'(en_o), 0);
    chk("sync tick", 32'(tick_o), 3);
    sync_i = 1'b0;
    b0 = e; b1 = e;
    run(13, "post sync");
`endif

    // Asynchronous clear mid-count.
    #2 clr = 1'b1;
    #1 chk("clr async en", 32'(en_o), 0);
    chk("clr async tick", 32'(tick_o), 3);
`ifdef CLKDIV_CFG_EN
    chk("clr ready", 32'(cfg_ready), 1);
`else
    chk("clr ready", 32'(cfg_ready), 0);
`endif
    @(negedge clk);
    clr = 1'b0;
    e = 0; b0 = 0; d0 = 2; b1 = 0; d1 = 9;
    run(20, "after clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
